// File: rtl/fpu_pkg.sv
// Shared types for the parametrised floating-point add/subtract unit.
package fpu_pkg;

  typedef enum logic [3:0] {
    ST_NONE      = 4'b0000,
    ST_EXACT     = 4'b0001,
    ST_INEXACT   = 4'b0010,
    ST_OVERFLOW  = 4'b0100,
    ST_UNDERFLOW = 4'b1000
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fpu_lzc #(
  parameter  int W  = 8,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (din[i]) cnt = CW'(W - 1 - i);
  end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point add/subtract with RNE rounding and one-hot status.
// Each FSM state registers one datapath stage; done follows accept by five edges.
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 26,
  localparam int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic             start_in,
  input  logic             op_in,
  input  logic [WIDTH-1:0] op_a_in,
  input  logic [WIDTH-1:0] op_b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] data_out,
  output logic [3:0]       status_out
);

  localparam int SW = MAN_W + 5;  // carry, hidden, fraction, guard, round, sticky
  localparam int AW = MAN_W + 3;  // aligned significand plus guard and round
  localparam int XW = EXP_W + 2;
  localparam int LW = $clog2(SW);
  localparam logic [EXP_W-1:0]     EXP_RSV = '1;
  localparam logic [EXP_W-1:0]     EXP_SAT = EXP_W'((1 << EXP_W) - 2);
  localparam logic signed [XW-1:0] EXP_OVF = XW'((1 << EXP_W) - 1);

  state_t                 state;
  logic [WIDTH-1:0]       a_q, b_q;
  op_t                    op_q;
  logic                   sat_q, sgn_q, sub_q;
  logic [EXP_W-1:0]       diff_q;
  logic signed [XW-1:0]   exp_q;
  logic [MAN_W:0]         big_q, sml_q;
  logic [SW-1:0]          x_q, y_q, sum_q;
  logic [SW-2:0]          nrm_q;

  // unpack: zero operands compare as magnitude 0 so the swap keeps |big| >= |small|
  logic [EXP_W-1:0]       ea, eb;
  logic                   sa, sb, swap;
  logic [EXP_W+MAN_W-1:0] ma, mb;
  logic [MAN_W:0]         sig_a, sig_b;

  always_comb begin
    ea    = a_q[WIDTH-2 -: EXP_W];
    eb    = b_q[WIDTH-2 -: EXP_W];
    sa    = a_q[WIDTH-1];
    sb    = b_q[WIDTH-1] ^ (op_q == OP_SUB);
    ma    = (ea == '0) ? '0 : a_q[WIDTH-2:0];
    mb    = (eb == '0) ? '0 : b_q[WIDTH-2:0];
    sig_a = (ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    sig_b = (eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    swap  = mb > ma;
  end

  // align: shifted-out bits collapse into sticky
  logic [2*AW-1:0] wide;
  logic [AW-1:0]   al;
  logic            st;

  always_comb begin
    wide = {sml_q, 2'b00, {AW{1'b0}}} >> diff_q;
    if (int'(diff_q) > MAN_W + 2) begin
      al = '0;
      st = |sml_q;
    end else begin
      al = wide[2*AW-1 -: AW];
      st = |wide[AW-1:0];
    end
  end

  logic [LW-1:0] lz;

  fpu_lzc #(.W(SW - 1)) u_lzc (
    .din (sum_q[SW-2:0]),
    .cnt (lz)
  );

  // round: a normalised nonzero result always has the hidden or carry bit set
  logic                 g, r, s, lsb, up, zero, oflow, uflow;
  logic [MAN_W+1:0]     man;
  logic signed [XW-1:0] fexp;

  always_comb begin
    lsb   = nrm_q[3];
    g     = nrm_q[2];
    r     = nrm_q[1];
    s     = nrm_q[0];
    up    = g & (r | s | lsb);
    man   = {1'b0, nrm_q[SW-2:3]} + {{(MAN_W+1){1'b0}}, up};
    fexp  = exp_q + XW'(man[MAN_W+1]);
    zero  = ~|man[MAN_W+1:MAN_W];
    oflow = fexp >= EXP_OVF;
    uflow = fexp[XW-1] || (fexp == '0);
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state      <= S_IDLE;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      data_out   <= '0;
      status_out <= ST_NONE;
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: if (start_in && !done_out) begin
          a_q      <= op_a_in;
          b_q      <= op_b_in;
          op_q     <= op_t'(op_in);
          busy_out <= 1'b1;
          state    <= S_UNPACK;
        end
        S_UNPACK: begin
          sat_q  <= (ea == EXP_RSV) || (eb == EXP_RSV);
          sgn_q  <= swap ? sb : sa;
          sub_q  <= sa ^ sb;
          exp_q  <= XW'(swap ? eb : ea);
          diff_q <= swap ? eb - ea : ea - eb;
          big_q  <= swap ? sig_b : sig_a;
          sml_q  <= swap ? sig_a : sig_b;
          state  <= S_ALIGN;
        end
        S_ALIGN: begin
          x_q   <= {1'b0, big_q, 3'b000};
          y_q   <= {1'b0, al, st};
          state <= S_ADD;
        end
        S_ADD: begin
          sum_q <= sub_q ? x_q - y_q : x_q + y_q;
          state <= S_NORM;
        end
        S_NORM: begin
          if (sum_q[SW-1]) begin
            nrm_q <= {sum_q[SW-1:2], |sum_q[1:0]};
            exp_q <= exp_q + XW'(1);
          end else begin
            nrm_q <= sum_q[SW-2:0] << lz;
            exp_q <= exp_q - XW'(lz);
          end
          state <= S_ROUND;
        end
        S_ROUND: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state    <= S_IDLE;
          if (sat_q || (!zero && oflow)) begin
            data_out   <= {sgn_q, EXP_SAT, {MAN_W{1'b1}}};
            status_out <= ST_OVERFLOW;
          end else if (zero) begin
            data_out   <= '0;
            status_out <= ST_EXACT;
          end else if (uflow) begin
            data_out   <= {sgn_q, {(WIDTH-1){1'b0}}};
            status_out <= ST_UNDERFLOW;
          end else begin
            data_out   <= {sgn_q, fexp[EXP_W-1:0], man[MAN_W-1:0]};
            status_out <= (g | r | s) ? ST_INEXACT : ST_EXACT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Bench for fpu_addsub_param: directed table, handshake corner sequences and
// random operands against an exact integer reference model.
module tb_fpu_addsub_param;

  logic        clk = 1'b0;
  logic        rst, start, op_sel;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] data;
  logic [3:0]  status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fpu_addsub_param #(.EXP_W(5), .MAN_W(26)) dut (
    .clock100KHz (clk),
    .reset       (rst),
    .start_in    (start),
    .op_in       (op_sel),
    .op_a_in     (op_a),
    .op_b_in     (op_b),
    .busy_out    (busy),
    .done_out    (done),
    .data_out    (data),
    .status_out  (status)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] d;
    logic [3:0]  st;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact value as integer * 2^(1-bias-MAN_W), then RNE to 27 significant bits.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                    output logic [31:0] d, output logic [3:0] st);
    logic [4:0]  ea, eb;
    logic [30:0] ma, mb;
    logic        sa, sb, sg;
    longint      ia, ib, sum, m, q, rem, half;
    int          p, sh, e;
    ea = a[30:26];
    eb = b[30:26];
    sa = a[31];
    sb = b[31] ^ op;
    ma = (ea == 0) ? 31'd0 : a[30:0];
    mb = (eb == 0) ? 31'd0 : b[30:0];
    if (ea == 5'h1f || eb == 5'h1f) begin
      sg = (ma >= mb) ? sa : sb;
      d  = {sg, 5'd30, 26'h3ffffff};
      st = 4'b0100;
      return;
    end
    ia  = (ea == 0) ? 64'sd0 : (longint'({1'b1, a[25:0]}) << (ea - 1));
    ib  = (eb == 0) ? 64'sd0 : (longint'({1'b1, b[25:0]}) << (eb - 1));
    sum = (sa ? -ia : ia) + (sb ? -ib : ib);
    if (sum == 0) begin
      d  = 32'h0;
      st = 4'b0001;
      return;
    end
    sg = sum < 0;
    m  = sg ? -sum : sum;
    p  = 0;
    for (int k = 0; k < 63; k++) if (m[k]) p = k;
    if (p < 26) begin
      d  = {sg, 31'h0};
      st = 4'b1000;
      return;
    end
    sh   = p - 26;
    q    = m >> sh;
    rem  = m - (q << sh);
    half = (sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0;
    if (sh > 0 && (rem > half || (rem == half && q[0]))) q++;
    e = sh + 1;
    if (q == (longint'(1) << 27)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 31) begin
      d  = {sg, 5'd30, 26'h3ffffff};
      st = 4'b0100;
    end else begin
      d  = {sg, 5'(e), q[25:0]};
      st = (rem != 0) ? 4'b0010 : 4'b0001;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                        output logic [31:0] d, output logic [3:0] s, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; op_sel = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    d = data;
    s = status;
  endtask

  vec_t        vecs[17];
  logic [31:0] d, ed;
  logic [3:0]  s, es;
  int          lat, cnt;
  logic [31:0] ra, rb;
  logic        ro;

  initial begin
    vecs[0]  = '{32'h3C000000, 32'h3C000000, 1'b0, 32'h40000000, 4'b0001};
    vecs[1]  = '{32'h70000000, 32'h04000000, 1'b0, 32'h70000000, 4'b0010}; // tie, stays even
    vecs[2]  = '{32'h70000001, 32'h04000000, 1'b0, 32'h70000002, 4'b0010}; // tie, rounds to even
    vecs[3]  = '{32'h7BFFFFFF, 32'h7BFFFFFF, 1'b0, 32'h7BFFFFFF, 4'b0100};
    vecs[4]  = '{32'h04000001, 32'h04000000, 1'b1, 32'h00000000, 4'b1000};
    vecs[5]  = '{32'h3C000000, 32'h3C000000, 1'b1, 32'h00000000, 4'b0001};
    vecs[6]  = '{32'h40000000, 32'h3C000000, 1'b1, 32'h3C000000, 4'b0001};
    vecs[7]  = '{32'h3C000000, 32'h0C000000, 1'b0, 32'h3C004000, 4'b0001};
    vecs[8]  = '{32'h7C000000, 32'h3C000000, 1'b0, 32'h7BFFFFFF, 4'b0100}; // reserved exponent
    vecs[9]  = '{32'hBC000000, 32'h3C000000, 1'b0, 32'h00000000, 4'b0001};
    vecs[10] = '{32'h3C000000, 32'hBC000000, 1'b1, 32'h40000000, 4'b0001};
    vecs[11] = '{32'h70000000, 32'h3C000000, 1'b0, 32'h70002000, 4'b0001};
    vecs[12] = '{32'h78000000, 32'h04000000, 1'b0, 32'h78000000, 4'b0010}; // sticky only
    vecs[13] = '{32'h00000005, 32'hBC000000, 1'b0, 32'hBC000000, 4'b0001}; // zero, fraction ignored
    vecs[14] = '{32'h3C000000, 32'h04000000, 1'b1, 32'h3BFFE000, 4'b0001};
    vecs[15] = '{32'h84000001, 32'h84000000, 1'b1, 32'h80000000, 4'b1000};
    vecs[16] = '{32'h73FFFFFF, 32'h04000000, 1'b0, 32'h74000000, 4'b0010}; // mantissa carry

    rst = 1'b1; start = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", data, 0);
    check("reset_status", status, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, d, s, lat);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_data", i), d, vecs[i].d);
      check($sformatf("vec%0d_status", i), s, vecs[i].st);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_held", i), data, vecs[i].d);
    end

    // abort: second start ignored, reset mid-operation clears everything
    @(negedge clk);
    op_a = 32'h3C000000; op_b = 32'h3C000000; op_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_after_accept", busy, 1);
    @(negedge clk);
    op_a = 32'h70000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data", data, 0);
    check("abort_status", status, 0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // start held through busy and the done cycle: only the first request runs
    @(negedge clk);
    op_a = 32'h3C000000; op_b = 32'h3C000000; op_sel = 1'b0; start = 1'b1;
    @(negedge clk);
    op_a = 32'h70000000; op_b = 32'h04000000;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = k;
    end
    check("hold_latency", lat, 5);
    check("hold_data", data, 32'h40000000);
    check("hold_status", status, 4'b0001);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("done_cycle_start_ignored", cnt, 0);

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 1'($urandom_range(0, 1));
      if (i % 2 == 1) rb[30:26] = ra[30:26] + 5'($urandom_range(0, 4)) - 5'd2;
      if (i % 17 == 0) rb = ra;
      ref_model(ra, rb, ro, ed, es);
      run_op(ra, rb, ro, d, s, lat);
      check($sformatf("rand%0d_data a=%h b=%h op=%0d", i, ra, rb, ro), d, ed);
      check($sformatf("rand%0d_status", i), s, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
